// File: rtl/demo_bus_pkg.sv
// Shared helpers for the demo bus crossbar.
// Contents:
//   idx_width(n) - index width for n items, never less than 1 bit.
package demo_bus_pkg;

    // $clog2(1) is 0, so a single host or device still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demo_bus_addr_decode.sv
// Combinational base/mask address decoder for the demo bus.
// Ports:
//   addr_i    - byte address to decode
//   base_i[]  - per-device region base
//   mask_i[]  - per-device region mask
//   dev_idx_o - index of the matching device (lowest index wins)
//   hit_o     - 1 when at least one device matched
module demo_bus_addr_decode
    import demo_bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int AddressWidth = 32,
    localparam int DevIdxW     = idx_width(NrDevices)
) (
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [AddressWidth-1:0] base_i [NrDevices],
    input  logic [AddressWidth-1:0] mask_i [NrDevices],
    output logic [DevIdxW-1:0]      dev_idx_o,
    output logic                    hit_o
);

    // Scan from the top down so the lowest-index match is the last write.
    always_comb begin
        dev_idx_o = '0;
        hit_o     = 1'b0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((addr_i & mask_i[d]) == base_i[d]) begin
                dev_idx_o = DevIdxW'(d);
                hit_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demo_bus.sv
// Single-cycle crossbar between bus hosts and memory-mapped devices.
// Fixed-priority host arbitration (host 0 highest), base/mask device decode,
// and routing of the one-cycle-later device response to the granted host.
// Ports:
//   clk_i, rst_ni                  - clock, async active-low reset
//   host_*_i / host_*_o [NrHosts]  - host request side and response side
//   device_*_o / device_*_i [NrDevices] - forwarded request, device response
//   cfg_device_addr_base/mask      - per-device address region
module demo_bus
    import demo_bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],

    output logic                      device_req_o         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = idx_width(NrHosts);
    localparam int DevIdxW  = idx_width(NrDevices);

    logic [HostIdxW-1:0]     host_sel_d, host_sel_q;
    logic [DevIdxW-1:0]      dev_sel_d, dev_sel_q;
    logic                    miss_q;
    logic                    valid_q;
    logic                    any_req;
    logic                    hit;

    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [DataWidth/8-1:0]  win_be;
    logic [DataWidth-1:0]    win_wdata;

    // Fixed priority: downward scan leaves the lowest requesting index.
    always_comb begin
        host_sel_d = '0;
        any_req    = 1'b0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                host_sel_d = HostIdxW'(h);
                any_req    = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (HostIdxW'(h) == host_sel_d) begin
                win_addr  = host_addr_i[h];
                win_we    = host_we_i[h];
                win_be    = host_be_i[h];
                win_wdata = host_wdata_i[h];
            end
        end
    end

    demo_bus_addr_decode #(
        .NrDevices    (NrDevices),
        .AddressWidth (AddressWidth)
    ) u_addr_decode (
        .addr_i    (win_addr),
        .base_i    (cfg_device_addr_base),
        .mask_i    (cfg_device_addr_mask),
        .dev_idx_o (dev_sel_d),
        .hit_o     (hit)
    );

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = host_req_i[h] && (HostIdxW'(h) == host_sel_d);
        end
    end

    // Unselected device ports are held at zero on every field.
    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_addr_o[d]  = '0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
            if (any_req && hit && (DevIdxW'(d) == dev_sel_d)) begin
                device_req_o[d]   = 1'b1;
                device_addr_o[d]  = win_addr;
                device_we_o[d]    = win_we;
                device_be_o[d]    = win_be;
                device_wdata_o[d] = win_wdata;
            end
        end
    end

    // Selection is only loaded on a grant cycle; valid_q tracks whether a
    // response is owed to a host in the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_sel_q <= '0;
            dev_sel_q  <= '0;
            miss_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= any_req;
            if (any_req) begin
                host_sel_q <= host_sel_d;
                dev_sel_q  <= dev_sel_d;
                miss_q     <= !hit;
            end
        end
    end

    // A decode miss is answered by the bus itself with an error response.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (valid_q && (HostIdxW'(h) == host_sel_q)) begin
                if (miss_q) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    for (int d = 0; d < NrDevices; d++) begin
                        if (DevIdxW'(d) == dev_sel_q) begin
                            host_rvalid_o[h] = device_rvalid_i[d];
                            host_rdata_o[h]  = device_rdata_i[d];
                            host_err_o[h]    = device_err_i[d];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demo_bus.sv
// Directed bench for demo_bus with the demo address map (2 hosts, 8 devices).
module tb_demo_bus;

    localparam int NH = 2;
    localparam int ND = 8;

    localparam int DevRam   = 0;
    localparam int DevGpio  = 1;
    localparam int DevPwm   = 2;
    localparam int DevUart  = 3;
    localparam int DevTimer = 4;
    localparam int DevSpi   = 5;
    localparam int DevSim   = 6;
    localparam int DevDbg   = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        host_req    [NH];
    logic        host_gnt    [NH];
    logic [31:0] host_addr   [NH];
    logic        host_we     [NH];
    logic [3:0]  host_be     [NH];
    logic [31:0] host_wdata  [NH];
    logic        host_rvalid [NH];
    logic [31:0] host_rdata  [NH];
    logic        host_err    [NH];

    logic        dev_req     [ND];
    logic [31:0] dev_addr    [ND];
    logic        dev_we      [ND];
    logic [3:0]  dev_be      [ND];
    logic [31:0] dev_wdata   [ND];
    logic        dev_rvalid  [ND];
    logic [31:0] dev_rdata   [ND];
    logic        dev_err     [ND];
    logic [31:0] cfg_base    [ND];
    logic [31:0] cfg_mask    [ND];

    logic [31:0] resp_data = '0;
    logic        resp_err  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demo_bus #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .host_req_i           (host_req),
        .host_gnt_o           (host_gnt),
        .host_addr_i          (host_addr),
        .host_we_i            (host_we),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_rvalid_o        (host_rvalid),
        .host_rdata_o         (host_rdata),
        .host_err_o           (host_err),
        .device_req_o         (dev_req),
        .device_addr_o        (dev_addr),
        .device_we_o          (dev_we),
        .device_be_o          (dev_be),
        .device_wdata_o       (dev_wdata),
        .device_rvalid_i      (dev_rvalid),
        .device_rdata_i       (dev_rdata),
        .device_err_i         (dev_err),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    // Device model: every device answers exactly one cycle after its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                dev_rvalid[d] <= 1'b0;
                dev_rdata[d]  <= '0;
                dev_err[d]    <= 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                dev_rvalid[d] <= dev_req[d];
                dev_rdata[d]  <= dev_req[d] ? resp_data : 32'h0;
                dev_err[d]    <= dev_req[d] & resp_err;
            end
        end
    end

    typedef struct {
        int          host;      // -1: no request
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] resp_data;
        logic        resp_err;
        int          exp_dev;   // -1: decode miss or idle
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_hosts();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_addr[h]  = '0;
            host_we[h]    = 1'b0;
            host_be[h]    = '0;
            host_wdata[h] = '0;
        end
    endtask

    task automatic chk_host_quiet(input string tag);
        logic [31:0] acc;
        acc = '0;
        for (int h = 0; h < NH; h++)
            acc = acc | {30'h0, host_rvalid[h], host_err[h]} | host_rdata[h];
        chk(tag, acc, 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]  req_mask, exp_mask;
        logic [31:0] others;
        logic        miss;
        @(negedge clk);
        idle_hosts();
        if (v.host >= 0) begin
            host_req[v.host]   = 1'b1;
            host_addr[v.host]  = v.addr;
            host_we[v.host]    = v.we;
            host_be[v.host]    = v.be;
            host_wdata[v.host] = v.wdata;
        end
        resp_data = v.resp_data;
        resp_err  = v.resp_err;
        #1;
        for (int h = 0; h < NH; h++)
            chk($sformatf("v%0d gnt%0d", idx, h), {31'h0, host_gnt[h]}, {31'h0, h == v.host});
        req_mask = '0;
        exp_mask = '0;
        others   = '0;
        for (int d = 0; d < ND; d++) begin
            req_mask[d] = dev_req[d];
            exp_mask[d] = (d == v.exp_dev);
            if (d != v.exp_dev)
                others = others | dev_addr[d] | dev_wdata[d] | {27'h0, dev_we[d], dev_be[d]};
        end
        chk($sformatf("v%0d dev_req", idx), {24'h0, req_mask}, {24'h0, exp_mask});
        chk($sformatf("v%0d idle_ports", idx), others, 32'h0);
        if (v.exp_dev >= 0) begin
            chk($sformatf("v%0d fwd_addr", idx), dev_addr[v.exp_dev], v.addr);
            chk($sformatf("v%0d fwd_wdata", idx), dev_wdata[v.exp_dev], v.wdata);
            chk($sformatf("v%0d fwd_we_be", idx), {27'h0, dev_we[v.exp_dev], dev_be[v.exp_dev]},
                {27'h0, v.we, v.be});
        end
        miss = (v.host >= 0) && (v.exp_dev < 0);
        @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            chk($sformatf("v%0d rvalid%0d", idx, h), {31'h0, host_rvalid[h]}, {31'h0, h == v.host});
            chk($sformatf("v%0d err%0d", idx, h), {31'h0, host_err[h]},
                {31'h0, (h == v.host) && (miss || v.resp_err)});
            chk($sformatf("v%0d rdata%0d", idx, h), host_rdata[h],
                ((h == v.host) && !miss) ? v.resp_data : 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_base[DevRam]   = 32'h0010_0000; cfg_mask[DevRam]   = 32'hFFF0_0000;
        cfg_base[DevGpio]  = 32'h8000_0000; cfg_mask[DevGpio]  = 32'hFFFF_F000;
        cfg_base[DevPwm]   = 32'h8000_3000; cfg_mask[DevPwm]   = 32'hFFFF_F000;
        cfg_base[DevUart]  = 32'h8000_1000; cfg_mask[DevUart]  = 32'hFFFF_F000;
        cfg_base[DevTimer] = 32'h8000_2000; cfg_mask[DevTimer] = 32'hFFFF_F000;
        cfg_base[DevSpi]   = 32'h8000_4000; cfg_mask[DevSpi]   = 32'hFFFF_F000;
        cfg_base[DevSim]   = 32'h0002_0000; cfg_mask[DevSim]   = 32'hFFFF_FC00;
        cfg_base[DevDbg]   = 32'h1A11_0000; cfg_mask[DevDbg]   = 32'hFFFF_8000;

        //          host addr           we    be    wdata          resp_data      err   exp_dev
        vecs[0]  = '{0, 32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, DevRam};
        vecs[1]  = '{0, 32'h8000_0000, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_00A5, 1'b0, DevGpio};
        vecs[2]  = '{1, 32'h4000_0000, 1'b0, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0, -1};
        vecs[3]  = '{0, 32'h8000_2004, 1'b0, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, DevTimer};
        vecs[4]  = '{1, 32'h8000_4008, 1'b1, 4'h3, 32'h0000_5A5A, 32'h0000_0000, 1'b0, DevSpi};
        vecs[5]  = '{0, 32'h1A11_0100, 1'b0, 4'hF, 32'h0000_0000, 32'hCAFE_0001, 1'b0, DevDbg};
        vecs[6]  = '{-1, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, -1};
        vecs[7]  = '{1, 32'h0002_0008, 1'b1, 4'h1, 32'h0000_0001, 32'h0000_0000, 1'b0, DevSim};
        vecs[8]  = '{0, 32'h8000_3000, 1'b0, 4'hF, 32'h0000_0000, 32'h7777_0000, 1'b0, DevPwm};
        vecs[9]  = '{0, 32'h001F_FFFC, 1'b1, 4'hC, 32'hA5A5_0000, 32'h0000_0000, 1'b0, DevRam};
        vecs[10] = '{0, 32'h0020_0000, 1'b0, 4'hF, 32'h0000_0000, 32'h5555_5555, 1'b0, -1};
        vecs[11] = '{1, 32'h8000_1000, 1'b1, 4'hF, 32'h0000_0041, 32'h0000_0000, 1'b0, DevUart};

        idle_hosts();
        #1;
        chk_host_quiet("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_host_quiet("post_reset_outputs");

        for (int i = 0; i < 12; i++)
            run_vec(i, vecs[i]);

        // Contention: host 0 wins first, host 1 retries and wins next cycle.
        @(negedge clk);
        idle_hosts();
        host_req[0] = 1'b1; host_addr[0] = 32'h8000_1000;
        host_req[1] = 1'b1; host_addr[1] = 32'h8000_2000;
        resp_data = 32'h0000_1111; resp_err = 1'b0;
        #1;
        chk("cont c1 gnt", {30'h0, host_gnt[1], host_gnt[0]}, 32'h1);
        chk("cont c1 uart_req", {31'h0, dev_req[DevUart]}, 32'h1);
        chk("cont c1 timer_req", {31'h0, dev_req[DevTimer]}, 32'h0);
        @(posedge clk);
        #1;
        chk("cont c2 rvalid", {30'h0, host_rvalid[1], host_rvalid[0]}, 32'h1);
        chk("cont c2 rdata0", host_rdata[0], 32'h0000_1111);
        @(negedge clk);
        host_req[0] = 1'b0; host_addr[0] = '0;
        resp_data = 32'h0000_2222;
        #1;
        chk("cont c2 gnt", {30'h0, host_gnt[1], host_gnt[0]}, 32'h2);
        chk("cont c2 timer_req", {31'h0, dev_req[DevTimer]}, 32'h1);
        chk("cont c2 timer_addr", dev_addr[DevTimer], 32'h8000_2000);
        @(posedge clk);
        #1;
        chk("cont c3 rvalid", {30'h0, host_rvalid[1], host_rvalid[0]}, 32'h2);
        chk("cont c3 rdata1", host_rdata[1], 32'h0000_2222);

        // Overlapping regions: the lower-index device must win the decode.
        cfg_base[DevDbg] = 32'h8000_0000; cfg_mask[DevDbg] = 32'hFFFF_F000;
        run_vec(100, '{1, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 32'h0000_0BB0, 1'b0, DevGpio});
        cfg_base[DevDbg] = 32'h1A11_0000; cfg_mask[DevDbg] = 32'hFFFF_8000;

        // Reset in the cycle after a grant drops the pending response.
        @(negedge clk);
        idle_hosts();
        host_req[0] = 1'b1; host_addr[0] = 32'h8000_0000;
        resp_data = 32'h0000_00A5; resp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle_hosts();
        rst_n = 1'b0;
        #1;
        chk_host_quiet("rst_mid quiet");
        @(posedge clk);
        #1;
        chk_host_quiet("rst_mid held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_host_quiet("rst_mid released");
        run_vec(200, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
